sblk_act_feeder: RTL and testbench

Producer-side end of the activation-buffer write interface of a conv row sub-block. It takes a stream of single activation words from upstream and packs them in pairs into a small FIFO. For each programmed burst, it answers the row's actbuf_wr_req by driving one registered actbuf_wr_data/actbuf_wr_vld beat per cycle. One instance sits beside each conv row, between the activation distribution network and the row's actbuf write port.

---
 rtl/sblk_act_feeder_if.sv | 26 ++
 rtl/sblk_act_feeder.sv | 161 ++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sblk_act_feeder_if.sv
// Upstream word stream and row actbuf write port of one conv-row activation feeder.
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 8
`endif

interface sblk_act_feeder_if #(
    parameter int DATA_W = `ACTBUF_DATA_LEN
);
    logic [DATA_W-1:0]   s_data;
    logic                s_vld;
    logic                s_rdy;
    logic                s_last;
    logic                actbuf_wr_req;
    logic                actbuf_wr_vld;
    logic [2*DATA_W-1:0] actbuf_wr_data;

    modport master (
        output s_data, s_vld, s_last, actbuf_wr_req,
        input  s_rdy, actbuf_wr_vld, actbuf_wr_data
    );

    modport slave (
        input  s_data, s_vld, s_last, actbuf_wr_req,
        output s_rdy, actbuf_wr_vld, actbuf_wr_data
    );
endinterface

// File: rtl/sblk_act_feeder.sv
// Packs upstream activation words in pairs into a FIFO and plays out programmed
// bursts of packed beats to the row actbuf write port.
//
//   state | meaning
//   IDLE  | no burst loaded; FIFO keeps filling, no beats driven
//   RUN   | burst active; one beat per cycle with req high and FIFO non-empty
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 8
`endif

module sblk_act_feeder #(
    parameter int DATA_W     = `ACTBUF_DATA_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] feed_param,
    input  logic             feed_param_en,
    output logic             feed_status,
    sblk_act_feeder_if.slave act
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [CNT_W-1:0]    beats_left;
    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         fifo_cnt;
    logic [DATA_W-1:0]   half;
    logic                half_vld;
    logic                half_last;

    logic                xfer;
    logic                pop;
    logic                space;
    logic                push;
    logic [2*DATA_W-1:0] push_data;
    logic [DATA_W-1:0]   half_nxt;
    logic                half_vld_nxt;
    logic                half_last_nxt;

    assign act.s_rdy = !half_vld || (fifo_cnt < DEPTH_C);
    assign xfer      = act.s_vld && act.s_rdy;
    assign pop       = (state == RUN) && act.actbuf_wr_req && (fifo_cnt != '0) && (beats_left != '0);
    assign space     = (fifo_cnt < DEPTH_C) || pop;

    // A group-closing word that meets a full FIFO is parked in the half register
    // (half_last) and its zero-padded pair is pushed as soon as a slot frees.
    always_comb begin
        push          = 1'b0;
        push_data     = '0;
        half_nxt      = half;
        half_vld_nxt  = half_vld;
        half_last_nxt = half_last;
        if (half_vld && half_last) begin
            if (space) begin
                push          = 1'b1;
                push_data     = {{DATA_W{1'b0}}, half};
                half_vld_nxt  = 1'b0;
                half_last_nxt = 1'b0;
                if (xfer) begin
                    half_nxt      = act.s_data;
                    half_vld_nxt  = 1'b1;
                    half_last_nxt = act.s_last;
                end
            end
        end else if (xfer) begin
            if (half_vld) begin
                push         = 1'b1;
                push_data    = {act.s_data, half};
                half_vld_nxt = 1'b0;
            end else if (!act.s_last) begin
                half_nxt      = act.s_data;
                half_vld_nxt  = 1'b1;
                half_last_nxt = 1'b0;
            end else if (space) begin
                push      = 1'b1;
                push_data = {{DATA_W{1'b0}}, act.s_data};
            end else begin
                half_nxt      = act.s_data;
                half_vld_nxt  = 1'b1;
                half_last_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_l) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            half      <= '0;
            half_vld  <= 1'b0;
            half_last <= 1'b0;
        end else begin
            half      <= half_nxt;
            half_vld  <= half_vld_nxt;
            half_last <= half_last_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            beats_left         <= '0;
            feed_status        <= 1'b0;
            act.actbuf_wr_vld  <= 1'b0;
            act.actbuf_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    act.actbuf_wr_vld <= 1'b0;
                    if (feed_param_en && (feed_param != '0)) begin
                        beats_left  <= feed_param;
                        state       <= RUN;
                        feed_status <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop) begin
                        act.actbuf_wr_vld  <= 1'b1;
                        act.actbuf_wr_data <= mem[rd_ptr];
                        beats_left         <= beats_left - 1'b1;
                        if (beats_left == CNT_W'(1)) begin
                            state       <= IDLE;
                            feed_status <= 1'b0;
                        end
                    end else begin
                        act.actbuf_wr_vld <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    feed_status <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sblk_act_feeder.sv
// Directed bench for sblk_act_feeder: bursts, odd groups, back-pressure, req gaps,
// ignored loads and asynchronous reset, with hand-computed expected beats.
module tb_sblk_act_feeder;
    logic        clk_l = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] feed_param = '0;
    logic        feed_param_en = 1'b0;
    logic        feed_status;
    int          checks = 0;
    int          errors = 0;
    int          accepted;

    sblk_act_feeder_if #(.DATA_W(8)) bus ();

    sblk_act_feeder #(.DATA_W(8), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk_l         (clk_l),
        .rst_n         (rst_n),
        .feed_param    (feed_param),
        .feed_param_en (feed_param_en),
        .feed_status   (feed_status),
        .act           (bus)
    );

    always #5 clk_l = ~clk_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_l);
        #1;
    endtask

    task automatic push(input logic [7:0] w, input logic last);
        int n = 0;
        bus.s_vld  = 1'b1;
        bus.s_data = w;
        bus.s_last = last;
        while (!bus.s_rdy && n < 50) begin
            step();
            n++;
        end
        chk("push_rdy", 32'(bus.s_rdy), 32'd1);
        step();
        bus.s_vld  = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic load(input logic [15:0] len);
        feed_param    = len;
        feed_param_en = 1'b1;
        step();
        feed_param_en = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [15:0] data, input logic status);
        step();
        chk({tag, "_vld"}, 32'(bus.actbuf_wr_vld), 32'd1);
        chk({tag, "_data"}, 32'(bus.actbuf_wr_data), 32'(data));
        chk({tag, "_status"}, 32'(feed_status), 32'(status));
    endtask

    initial begin
        bus.s_data = '0;
        bus.s_vld = 1'b0;
        bus.s_last = 1'b0;
        bus.actbuf_wr_req = 1'b0;
        #12 rst_n = 1'b1;
        step();
        chk("rst_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        chk("rst_data", 32'(bus.actbuf_wr_data), 32'd0);
        chk("rst_status", 32'(feed_status), 32'd0);
        chk("rst_rdy", 32'(bus.s_rdy), 32'd1);

        // Basic burst of four back-to-back beats
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
        bus.actbuf_wr_req = 1'b1;
        load(16'd4);
        chk("basic_load_status", 32'(feed_status), 32'd1);
        chk("basic_load_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        beat("basic0", 16'h0201, 1'b1);
        beat("basic1", 16'h0403, 1'b1);
        beat("basic2", 16'h0605, 1'b1);
        beat("basic3", 16'h0807, 1'b0);
        step();
        chk("basic_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);

        // Odd group: last word zero-padded
        push(8'd9, 1'b0);
        push(8'd10, 1'b0);
        push(8'd11, 1'b1);
        chk("odd_idle_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        load(16'd2);
        beat("odd0", 16'h0A09, 1'b1);
        beat("odd1", 16'h000B, 1'b0);
        step();
        chk("odd_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        bus.actbuf_wr_req = 1'b0;

        // Req gaps: 1,0,1,0,1
        for (int i = 0; i < 6; i++) push(8'(8'h21 + i), 1'b0);
        load(16'd3);
        bus.actbuf_wr_req = 1'b1;
        beat("gap0", 16'h2221, 1'b1);
        bus.actbuf_wr_req = 1'b0;
        step();
        chk("gap1_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        chk("gap1_hold", 32'(bus.actbuf_wr_data), 32'h2221);
        bus.actbuf_wr_req = 1'b1;
        beat("gap2", 16'h2423, 1'b1);
        bus.actbuf_wr_req = 1'b0;
        step();
        chk("gap3_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        bus.actbuf_wr_req = 1'b1;
        beat("gap4", 16'h2625, 1'b0);
        step();
        chk("gap_extra_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        bus.actbuf_wr_req = 1'b0;

        // Ignored loads and surplus carried to the next burst
        load(16'd0);
        chk("zero_load_status", 32'(feed_status), 32'd0);
        for (int i = 0; i < 6; i++) push(8'(8'h41 + i), 1'b0);
        load(16'd2);
        load(16'd5);
        chk("run_load_status", 32'(feed_status), 32'd1);
        bus.actbuf_wr_req = 1'b1;
        beat("ign0", 16'h4241, 1'b1);
        beat("ign1", 16'h4443, 1'b0);
        step();
        chk("ign_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        load(16'd1);
        beat("surplus", 16'h4645, 1'b0);
        step();
        chk("surplus_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        bus.actbuf_wr_req = 1'b0;

        // Back-pressure: 8 pairs plus one half word fill the feeder
        accepted = 0;
        bus.s_vld = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            bus.s_data = 8'(i);
            if (!bus.s_rdy) break;
            step();
            accepted++;
        end
        chk("bp_accepted", 32'(accepted), 32'd17);
        chk("bp_rdy_low", 32'(bus.s_rdy), 32'd0);
        bus.actbuf_wr_req = 1'b1;
        load(16'd8);
        chk("bp_load_rdy", 32'(bus.s_rdy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            beat("bp_beat", {8'(2*k+2), 8'(2*k+1)}, (k < 7));
            if (k == 0) chk("bp_rdy_rise", 32'(bus.s_rdy), 32'd1);
            if (k == 1) bus.s_vld = 1'b0;
        end
        step();
        chk("bp_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);

        // Async reset mid-burst discards FIFO contents
        for (int i = 0; i < 4; i++) push(8'(8'h51 + i), 1'b0);
        load(16'd3);
        beat("rst_pre", 16'h1211, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        chk("arst_status", 32'(feed_status), 32'd0);
        chk("arst_data", 32'(bus.actbuf_wr_data), 32'd0);
        repeat (2) @(posedge clk_l);
        #3 rst_n = 1'b1;
        step();
        chk("arst_rdy", 32'(bus.s_rdy), 32'd1);
        chk("arst_idle_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        load(16'd1);
        beat("arst_new", 16'h6261, 1'b0);
        step();
        chk("arst_end_vld", 32'(bus.actbuf_wr_vld), 32'd0);
        bus.actbuf_wr_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
